// File: rtl/conveyor_risk_encoder_if.sv
// Sensor/flag bundle between the sensor front-end and the risk encoder.
// master: drives raw sensors, reads flags; slave: the encoder itself.
interface conveyor_risk_encoder_if;
  logic       sample_valid;
  logic [7:0] temp;
  logic       jam_in;
  logic       estop_in;
  logic       ack_in;
  logic       A;
  logic       C;
  logic [1:0] state;
  logic [2:0] fault_code;

  modport master (
    output sample_valid, temp, jam_in, estop_in, ack_in,
    input  A, C, state, fault_code
  );

  modport slave (
    input  sample_valid, temp, jam_in, estop_in, ack_in,
    output A, C, state, fault_code
  );
endinterface

// File: rtl/conveyor_risk_encoder.sv
// Risk encoder: temp hysteresis, jam debounce, estop sync -> registered A/C flags.
// Ports: clk, rst (async high), bus (slave: sensors in; A, C, state, fault_code out).
// Macro CONVEYOR_CRIT_LATCH_EN: CRIT held until ack_in; else auto-exit.
module conveyor_risk_encoder #(
  parameter logic [7:0] WARN_TH  = 8'd150,
  parameter logic [7:0] WARN_CLR = 8'd140,
  parameter logic [7:0] CRIT_TH  = 8'd200,
  parameter int         DEB_CYC  = 4,
  parameter int         JAM_CYC  = 16
) (
  input logic                    clk,
  input logic                    rst,
  conveyor_risk_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    NORM = 2'b00,
    WARN = 2'b01,
    CRIT = 2'b10
  } state_t;

  localparam logic [7:0] DEB_L  = 8'(DEB_CYC);
  localparam logic [7:0] DEB_M1 = 8'(DEB_CYC - 1);
  localparam logic [7:0] JAM_L  = 8'(JAM_CYC);

  logic       t_warn;
  logic       t_crit;
  logic [7:0] jam_cnt;
  logic       es1;
  logic       es2;
  logic [7:0] rel_cnt;
  state_t     st;
  state_t     nxt;
  logic       a_q;
  logic       c_q;
  logic [2:0] fc_q;

  logic       j_warn;
  logic       j_crit;
  logic       warn_cause;
  logic       crit_cause;
  logic [2:0] causes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_warn <= 1'b0;
      t_crit <= 1'b0;
    end else if (bus.sample_valid) begin
      t_crit <= (bus.temp >= CRIT_TH);
      if (bus.temp >= WARN_TH)
        t_warn <= 1'b1;
      else if (bus.temp < WARN_CLR)
        t_warn <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      jam_cnt <= '0;
    else if (!bus.jam_in)
      jam_cnt <= '0;
    else if (jam_cnt < JAM_L)
      jam_cnt <= jam_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      es1 <= 1'b0;
      es2 <= 1'b0;
    end else begin
      es1 <= bus.estop_in;
      es2 <= es1;
    end
  end

  assign j_warn     = (jam_cnt >= DEB_L);
  assign j_crit     = (jam_cnt >= JAM_L);
  assign warn_cause = t_warn | j_warn;
  assign causes     = {j_crit, t_crit, es2};
  assign crit_cause = |causes;

`ifdef CONVEYOR_CRIT_LATCH_EN
  logic leave_crit;
  assign leave_crit = bus.ack_in;
`else
  logic leave_crit;
  logic unused_ack;
  assign leave_crit = 1'b1;
  assign unused_ack = bus.ack_in;
`endif

  always_comb begin
    nxt = st;
    unique case (st)
      NORM: begin
        if (crit_cause)      nxt = CRIT;
        else if (warn_cause) nxt = WARN;
      end
      WARN: begin
        if (crit_cause)
          nxt = CRIT;
        else if (!warn_cause && rel_cnt == DEB_M1)
          nxt = NORM;
      end
      CRIT: begin
        if (!crit_cause && leave_crit)
          nxt = warn_cause ? WARN : NORM;
      end
      default: nxt = CRIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= NORM;
      a_q     <= 1'b0;
      c_q     <= 1'b0;
      fc_q    <= '0;
      rel_cnt <= '0;
    end else begin
      st  <= nxt;
      a_q <= (nxt != NORM);
      c_q <= (nxt == CRIT);
      // accumulate causes while CRIT persists, fresh load on entry
      if (nxt == CRIT)
        fc_q <= ((st == CRIT) ? fc_q : 3'b000) | causes;
      else
        fc_q <= '0;
      if (st == WARN && nxt == WARN && !warn_cause)
        rel_cnt <= rel_cnt + 8'd1;
      else
        rel_cnt <= '0;
    end
  end

  assign bus.A          = a_q;
  assign bus.C          = c_q;
  assign bus.state      = st;
  assign bus.fault_code = fc_q;

endmodule

// File: tb/tb_conveyor_risk_encoder.sv
// Directed bench for conveyor_risk_encoder.
// Covers temp hysteresis, crit exit, jam escalation, estop, accumulation, async reset.
module tb_conveyor_risk_encoder;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  conveyor_risk_encoder_if bus();

  conveyor_risk_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] t);
    bus.sample_valid = 1'b1;
    bus.temp = t;
    step();
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.temp = 8'd0;
    bus.jam_in = 1'b0;
    bus.estop_in = 1'b0;
    bus.ack_in = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_A", 8'(bus.A), 8'd0);
    chk("rst_C", 8'(bus.C), 8'd0);
    chk("rst_state", 8'(bus.state), 8'd0);
    chk("rst_fc", 8'(bus.fault_code), 8'd0);

    // hysteresis: 160 sets, 145 holds, 139 clears after 4-cycle release
    sample(8'd160);
    chk("warn_lat", 8'(bus.A), 8'd0);
    step();
    chk("warn_set_A", 8'(bus.A), 8'd1);
    chk("warn_state", 8'(bus.state), 8'd1);
    sample(8'd145);
    step();
    chk("warn_hold145", 8'(bus.A), 8'd1);
    sample(8'd139);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("rel_hold%0d", i), 8'(bus.A), 8'd1);
    end
    step();
    chk("rel_done_A", 8'(bus.A), 8'd0);
    chk("rel_done_C", 8'(bus.C), 8'd0);

    // temp critical
    sample(8'd210);
    chk("tcrit_lat", 8'(bus.C), 8'd0);
    step();
    chk("tcrit_C", 8'(bus.C), 8'd1);
    chk("tcrit_A", 8'(bus.A), 8'd1);
    chk("tcrit_state", 8'(bus.state), 8'd2);
    chk("tcrit_fc", 8'(bus.fault_code), 8'd2);
    sample(8'd100);
    chk("tcrit_still", 8'(bus.C), 8'd1);
    step();
`ifdef CONVEYOR_CRIT_LATCH_EN
    chk("latch_hold", 8'(bus.C), 8'd1);
    step();
    chk("latch_hold2", 8'(bus.C), 8'd1);
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
`endif
    chk("texit_C", 8'(bus.C), 8'd0);
    chk("texit_state", 8'(bus.state), 8'd0);
    chk("texit_fc", 8'(bus.fault_code), 8'd0);

    // jam: A at edge 5, C at edge 17
    bus.jam_in = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 4 || n == 5)
        chk($sformatf("jam_A_e%0d", n), 8'(bus.A), 8'(n >= 5));
      if (n == 16 || n == 17)
        chk($sformatf("jam_C_e%0d", n), 8'(bus.C), 8'(n >= 17));
    end
    chk("jam_fc", 8'(bus.fault_code), 8'd4);
    bus.jam_in = 1'b0;
    step();
    chk("jam_still", 8'(bus.C), 8'd1);
    step();
`ifdef CONVEYOR_CRIT_LATCH_EN
    chk("jam_latch", 8'(bus.C), 8'd1);
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
`endif
    chk("jam_exit", 8'(bus.state), 8'd0);

    // 1-cycle estop with ack held
    bus.ack_in = 1'b1;
    bus.estop_in = 1'b1;
    step();
    bus.estop_in = 1'b0;
    chk("es_e0", 8'(bus.C), 8'd0);
    step();
    chk("es_e1", 8'(bus.C), 8'd0);
    step();
    chk("es_e2_C", 8'(bus.C), 8'd1);
    chk("es_fc", 8'(bus.fault_code), 8'd1);
    step();
    chk("es_exit", 8'(bus.C), 8'd0);
    chk("es_exit_st", 8'(bus.state), 8'd0);
    bus.ack_in = 1'b0;

    // estop + temp 220 together: fault code accumulates
    bus.estop_in = 1'b1;
    sample(8'd220);
    bus.estop_in = 1'b0;
    step();
    chk("acc_fc1", 8'(bus.fault_code), 8'd2);
    step();
    chk("acc_fc2", 8'(bus.fault_code), 8'd3);
    chk("acc_C", 8'(bus.C), 8'd1);

    // async reset mid-CRIT, no clock edge
    #2 rst = 1'b1;
    #1;
    chk("arst_A", 8'(bus.A), 8'd0);
    chk("arst_C", 8'(bus.C), 8'd0);
    chk("arst_state", 8'(bus.state), 8'd0);
    chk("arst_fc", 8'(bus.fault_code), 8'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_C", 8'(bus.C), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
